sp_usb_device: RTL and testbench
================================

Name: sp_usb_device

Overview:
- Synthesizable model of the USB FIFO chip side of the synchronous 8-bit FIFO interface.
- Faces the FPGA-side USB sync bridge over usb_data/rxf_n/txe_n/rd_n/wr_n.
- Exposes a host-side byte port, so benches and loopback builds can inject bytes toward the FPGA and drain bytes the FPGA sends.
- Contains two FIFOs: RX (host to FPGA) and TX (FPGA to host).

Parameters:
- DEPTH_LOG2, 4, log2 of each FIFO's depth (default depth 16 bytes).

Ports:
- clk  in  1  single clock for everything.
- rst_n  in  1  asynchronous, active-low reset.
- usb_data  inout  8  shared data bus.
- rxf_n  out  1  low: RX FIFO has a byte for the FPGA.
- txe_n  out  1  low: TX FIFO can accept a byte from the FPGA.
- rd_n  in  1  FPGA read strobe, active low.
- wr_n  in  1  FPGA write strobe, active low.
- host_din  in  8  byte to enqueue into RX.
- host_write  in  1  enqueue strobe.
- host_full  out  1  RX full.
- host_dout  out  8  head of TX (show-ahead).
- host_read  in  1  dequeue strobe.
- host_avail  out  1  TX non-empty.
- rx_count  out  DEPTH_LOG2+1  RX occupancy.
- tx_count  out  DEPTH_LOG2+1  TX occupancy.
- err_underrun  out  1  sticky: rd_n low while RX empty.
- err_overrun  out  1  sticky: write dropped because TX full.

Behaviour:

Reset:
- rst_n low asynchronously clears all pointers, counts, error flags and the ready register.
- Output values while in reset: rxf_n=1, txe_n=1, host_full=0, host_avail=0, counts=0, usb_data=Z.

Ready register:
- Set on the first clk edge after rst_n deasserts.
- rxf_n = rx_empty | !ready; txe_n = tx_full | !ready.
- Both flags are combinational from occupancy, so they update the cycle after a push or pop.

FIFOs:
- Each FIFO uses a circular buffer with DEPTH_LOG2+1-bit read and write pointers.
- Wrap is by natural overflow.
- Full when the pointer MSBs differ and the remaining bits are equal; empty when the pointers are equal.
- Count = wptr - rptr.

RX path (host to FPGA):
- host_write with RX not full pushes host_din.
- host_write while full is ignored; no error flag is set, because host_full is the host's flow control.
- Device drives usb_data = RX head combinationally whenever rd_n=0 and ready=1; otherwise usb_data=Z.
- At a clk edge with rd_n=0 and RX non-empty: pop one byte. Latency is 0: the FPGA samples the byte at the same edge.
- rd_n=0 with RX empty: no pop, err_underrun<=1, bus still driven with stale memory data.

TX path (FPGA to host):
- Bus capture register bus_q <= usb_data on every edge where the device is not driving.
- The FPGA drives data in the cycle before wr_n goes low. At an edge with wr_n=0, push bus_q, not the live bus.
- wr_n=0 with TX full: byte dropped, err_overrun<=1.
- host_dout = TX head, valid while host_avail=1.
- host_read with host_avail pops; host_read while empty is ignored.

Simultaneous events:
- Push and pop on the same FIFO in one cycle are both honoured; count is unchanged.
- When full, a same-cycle push is accepted only if a pop also occurs that cycle.
- When empty, a same-cycle pop is not performed. The pushed byte is not bypassed and is visible the next cycle.
- rd_n and wr_n both low in one cycle: both operations proceed independently. The device still drives the bus, so the TX push uses the previous cycle's bus_q.

Error flags:
- Sticky; cleared only by reset.

Reset mid-operation:
- Any in-flight strobes are discarded and the FIFO contents are lost.
- usb_data goes Z immediately on rst_n low.

Test Plan:
- Release reset, then host_write 0x11, 0x22, 0x33 on consecutive cycles -> rxf_n low from the cycle after the first write. rd_n pulses return 0x11, 0x22, 0x33 in order on usb_data; rxf_n high after the third pop; rx_count goes 3 -> 0.
- FPGA drives 0xA5 then pulses wr_n low the next cycle, then repeats with 0x5A -> host_avail=1, host_dout=0xA5. host_read gives 0x5A; second host_read clears host_avail.
- Fill TX with 16 bytes -> txe_n=1, tx_count=16. A 17th wr_n pulse is dropped and err_overrun=1. After one host_read, txe_n=0 and a write is accepted with tx_count=16.
- RX holds 16 entries -> host_full=1. The same cycle carries rd_n=0 and host_write 0x77 -> both accepted, rx_count stays 16, 0x77 appears as the last byte drained.
- rd_n low with RX empty -> err_underrun=1 and rx_count stays 0. The flag stays set until rst_n pulses low.
- Assert rst_n low asynchronously mid-cycle with 5 bytes queued each way -> counts 0, rxf_n=1, txe_n=1, usb_data=Z immediately. txe_n=0 one edge after release.

Source files
------------

// File: rtl/sp_usb_device.sv
// USB FIFO chip model for the synchronous 8-bit FIFO interface.
// RX carries host bytes to the FPGA, TX carries FPGA bytes to the host.
module sp_usb_device #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  inout  wire  [7:0]            usb_data,
  output logic                  rxf_n,
  output logic                  txe_n,
  input  logic                  rd_n,
  input  logic                  wr_n,
  input  logic [7:0]            host_din,
  input  logic                  host_write,
  output logic                  host_full,
  output logic [7:0]            host_dout,
  input  logic                  host_read,
  output logic                  host_avail,
  output logic [DEPTH_LOG2:0]   rx_count,
  output logic [DEPTH_LOG2:0]   tx_count,
  output logic                  err_underrun,
  output logic                  err_overrun
);

  localparam int AW    = DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic          ready;

  logic [7:0]    rx_mem [DEPTH];
  logic [PW-1:0] rx_wptr;
  logic [PW-1:0] rx_rptr;
  logic          rx_full;
  logic          rx_empty;
  logic          rx_push;
  logic          rx_pop;
  logic [7:0]    rx_head;

  logic [7:0]    tx_mem [DEPTH];
  logic [PW-1:0] tx_wptr;
  logic [PW-1:0] tx_rptr;
  logic          tx_full;
  logic          tx_empty;
  logic          tx_push;
  logic          tx_pop;

  logic          drive;
  logic [7:0]    bus_q;
  logic          underrun_evt;
  logic          overrun_evt;

  // Ready comes up one edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready <= 1'b0;
    end else begin
      ready <= 1'b1;
    end
  end

  // Occupancy decode for both FIFOs.
  always_comb begin
    rx_empty = (rx_wptr == rx_rptr);
    rx_full  = (rx_wptr[AW] != rx_rptr[AW]) &&
               (rx_wptr[AW-1:0] == rx_rptr[AW-1:0]);
    tx_empty = (tx_wptr == tx_rptr);
    tx_full  = (tx_wptr[AW] != tx_rptr[AW]) &&
               (tx_wptr[AW-1:0] == tx_rptr[AW-1:0]);
    rx_count = rx_wptr - rx_rptr;
    tx_count = tx_wptr - tx_rptr;
  end

  // Push/pop qualification; a pop frees the slot a full-FIFO push needs.
  always_comb begin
    rx_pop       = !rd_n && !rx_empty;
    rx_push      = host_write && (!rx_full || rx_pop);
    underrun_evt = !rd_n && rx_empty;
    tx_pop       = host_read && !tx_empty;
    tx_push      = !wr_n && (!tx_full || tx_pop);
    overrun_evt  = !wr_n && tx_full && !tx_pop;
  end

  // Handshake flags and host-side views.
  always_comb begin
    rxf_n      = rx_empty || !ready;
    txe_n      = tx_full || !ready;
    host_full  = rx_full;
    host_avail = !tx_empty;
    rx_head    = rx_mem[rx_rptr[AW-1:0]];
    host_dout  = tx_mem[tx_rptr[AW-1:0]];
    drive      = !rd_n && ready;
  end

  // Bus is released as soon as ready drops, including async reset.
  assign usb_data = drive ? rx_head : 8'hzz;

  // RX storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (rx_push) begin
      rx_mem[rx_wptr[AW-1:0]] <= host_din;
    end
  end

  // TX storage takes the byte captured the cycle before wr_n.
  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem[tx_wptr[AW-1:0]] <= bus_q;
    end
  end

  // RX pointers advance on accepted push/pop, wrapping naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wptr <= '0;
      rx_rptr <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + 1'b1;
      if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
    end
  end

  // TX pointers advance on accepted push/pop, wrapping naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + 1'b1;
      if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
    end
  end

  // Capture the bus only while the FPGA may be driving it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_q <= 8'h00;
    end else if (!drive) begin
      bus_q <= usb_data;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_underrun <= 1'b0;
      err_overrun  <= 1'b0;
    end else begin
      if (underrun_evt) err_underrun <= 1'b1;
      if (overrun_evt)  err_overrun  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sp_usb_device.sv
// Directed bench for sp_usb_device.
// Scenario tasks run in sequence from one initial block.
module tb_sp_usb_device;

  logic       clk;
  logic       rst_n;
  wire  [7:0] usb_data;
  logic       rxf_n;
  logic       txe_n;
  logic       rd_n;
  logic       wr_n;
  logic [7:0] host_din;
  logic       host_write;
  logic       host_full;
  logic [7:0] host_dout;
  logic       host_read;
  logic       host_avail;
  logic [4:0] rx_count;
  logic [4:0] tx_count;
  logic       err_underrun;
  logic       err_overrun;

  logic       fpga_oe;
  logic [7:0] fpga_d;

  int checks;
  int errors;

  assign usb_data = fpga_oe ? fpga_d : 8'hzz;

  sp_usb_device #(.DEPTH_LOG2(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .usb_data     (usb_data),
    .rxf_n        (rxf_n),
    .txe_n        (txe_n),
    .rd_n         (rd_n),
    .wr_n         (wr_n),
    .host_din     (host_din),
    .host_write   (host_write),
    .host_full    (host_full),
    .host_dout    (host_dout),
    .host_read    (host_read),
    .host_avail   (host_avail),
    .rx_count     (rx_count),
    .tx_count     (tx_count),
    .err_underrun (err_underrun),
    .err_overrun  (err_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fpga_write(input logic [7:0] b);
    fpga_oe = 1'b1;
    fpga_d  = b;
    wr_n    = 1'b1;
    cyc();
    wr_n    = 1'b0;
    fpga_d  = 8'h00;
    cyc();
    wr_n    = 1'b1;
    fpga_oe = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (rxf_n !== 1'b1 || txe_n !== 1'b1) begin
      errors++;
      $display("FAIL reset_flags got rxf_n=%b txe_n=%b exp 1 1", rxf_n, txe_n);
    end
    checks++;
    if (host_full !== 1'b0 || host_avail !== 1'b0 ||
        rx_count !== 5'd0 || tx_count !== 5'd0) begin
      errors++;
      $display("FAIL reset_state got full=%b avail=%b rxc=%0d txc=%0d exp 0 0 0 0",
               host_full, host_avail, rx_count, tx_count);
    end
    cyc();
    cyc();
    rst_n = 1'b1;
    #1;
    checks++;
    if (txe_n !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_edge got txe_n=%b exp 1", txe_n);
    end
    cyc();
    checks++;
    if (txe_n !== 1'b0 || rxf_n !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_edge got txe_n=%b rxf_n=%b exp 0 1", txe_n, rxf_n);
    end
  endtask

  task automatic test_rx_basic();
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h11;
    exp_b[1] = 8'h22;
    exp_b[2] = 8'h33;
    host_write = 1'b1;
    host_din   = 8'h11;
    cyc();
    checks++;
    if (rxf_n !== 1'b0) begin
      errors++;
      $display("FAIL rx_first_rxf got %b exp 0", rxf_n);
    end
    host_din = 8'h22;
    cyc();
    host_din = 8'h33;
    cyc();
    host_write = 1'b0;
    checks++;
    if (rx_count !== 5'd3) begin
      errors++;
      $display("FAIL rx_count3 got %0d exp 3", rx_count);
    end
    for (int i = 0; i < 3; i++) begin
      rd_n = 1'b0;
      #1;
      checks++;
      if (usb_data !== exp_b[i]) begin
        errors++;
        $display("FAIL rx_read%0d got %h exp %h", i, usb_data, exp_b[i]);
      end
      cyc();
    end
    rd_n = 1'b1;
    #1;
    checks++;
    if (rxf_n !== 1'b1 || rx_count !== 5'd0) begin
      errors++;
      $display("FAIL rx_drained got rxf_n=%b cnt=%0d exp 1 0", rxf_n, rx_count);
    end
  endtask

  task automatic test_tx_basic();
    fpga_write(8'hA5);
    fpga_write(8'h5A);
    checks++;
    if (host_avail !== 1'b1 || host_dout !== 8'hA5 || tx_count !== 5'd2) begin
      errors++;
      $display("FAIL tx_head got avail=%b dout=%h cnt=%0d exp 1 a5 2",
               host_avail, host_dout, tx_count);
    end
    host_read = 1'b1;
    cyc();
    host_read = 1'b0;
    checks++;
    if (host_dout !== 8'h5A) begin
      errors++;
      $display("FAIL tx_second got %h exp 5a", host_dout);
    end
    host_read = 1'b1;
    cyc();
    host_read = 1'b0;
    checks++;
    if (host_avail !== 1'b0) begin
      errors++;
      $display("FAIL tx_empty got avail=%b exp 0", host_avail);
    end
    host_read = 1'b1;
    cyc();
    host_read = 1'b0;
    checks++;
    if (tx_count !== 5'd0) begin
      errors++;
      $display("FAIL tx_read_empty got cnt=%0d exp 0", tx_count);
    end
  endtask

  task automatic test_tx_full();
    checks++;
    if (err_overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_pre got %b exp 0", err_overrun);
    end
    for (int i = 0; i < 16; i++) fpga_write(8'h40 + 8'(i));
    checks++;
    if (txe_n !== 1'b1 || tx_count !== 5'd16) begin
      errors++;
      $display("FAIL tx_full got txe_n=%b cnt=%0d exp 1 16", txe_n, tx_count);
    end
    fpga_write(8'hEE);
    checks++;
    if (err_overrun !== 1'b1 || tx_count !== 5'd16 || host_dout !== 8'h40) begin
      errors++;
      $display("FAIL tx_overrun got err=%b cnt=%0d head=%h exp 1 16 40",
               err_overrun, tx_count, host_dout);
    end
    host_read = 1'b1;
    cyc();
    host_read = 1'b0;
    checks++;
    if (txe_n !== 1'b0 || tx_count !== 5'd15) begin
      errors++;
      $display("FAIL tx_after_pop got txe_n=%b cnt=%0d exp 0 15", txe_n, tx_count);
    end
    fpga_write(8'h99);
    checks++;
    if (tx_count !== 5'd16) begin
      errors++;
      $display("FAIL tx_refill got cnt=%0d exp 16", tx_count);
    end
    for (int i = 1; i < 17; i++) begin
      logic [7:0] e;
      e = (i == 16) ? 8'h99 : 8'h40 + 8'(i);
      checks++;
      if (host_dout !== e) begin
        errors++;
        $display("FAIL tx_order%0d got %h exp %h", i, host_dout, e);
      end
      host_read = 1'b1;
      cyc();
      host_read = 1'b0;
    end
    checks++;
    if (host_avail !== 1'b0 || tx_count !== 5'd0) begin
      errors++;
      $display("FAIL tx_full_drain got avail=%b cnt=%0d exp 0 0", host_avail, tx_count);
    end
  endtask

  task automatic test_rx_full_simul();
    host_write = 1'b1;
    for (int i = 0; i < 16; i++) begin
      host_din = 8'h80 + 8'(i);
      cyc();
    end
    host_din = 8'hCC;
    cyc();
    host_write = 1'b0;
    checks++;
    if (host_full !== 1'b1 || rx_count !== 5'd16) begin
      errors++;
      $display("FAIL rx_full got full=%b cnt=%0d exp 1 16", host_full, rx_count);
    end
    rd_n       = 1'b0;
    host_write = 1'b1;
    host_din   = 8'h77;
    #1;
    checks++;
    if (usb_data !== 8'h80) begin
      errors++;
      $display("FAIL rx_simul_data got %h exp 80", usb_data);
    end
    cyc();
    rd_n       = 1'b1;
    host_write = 1'b0;
    checks++;
    if (rx_count !== 5'd16 || host_full !== 1'b1) begin
      errors++;
      $display("FAIL rx_simul_count got cnt=%0d full=%b exp 16 1", rx_count, host_full);
    end
    for (int i = 1; i < 17; i++) begin
      logic [7:0] e;
      e = (i == 16) ? 8'h77 : 8'h80 + 8'(i);
      rd_n = 1'b0;
      #1;
      checks++;
      if (usb_data !== e) begin
        errors++;
        $display("FAIL rx_order%0d got %h exp %h", i, usb_data, e);
      end
      cyc();
    end
    rd_n = 1'b1;
    #1;
    checks++;
    if (rx_count !== 5'd0 || rxf_n !== 1'b1) begin
      errors++;
      $display("FAIL rx_full_drain got cnt=%0d rxf_n=%b exp 0 1", rx_count, rxf_n);
    end
  endtask

  task automatic test_underrun();
    checks++;
    if (err_underrun !== 1'b0) begin
      errors++;
      $display("FAIL underrun_pre got %b exp 0", err_underrun);
    end
    rd_n = 1'b0;
    cyc();
    rd_n = 1'b1;
    checks++;
    if (err_underrun !== 1'b1 || rx_count !== 5'd0) begin
      errors++;
      $display("FAIL underrun got err=%b cnt=%0d exp 1 0", err_underrun, rx_count);
    end
    host_write = 1'b1;
    host_din   = 8'h01;
    cyc();
    host_write = 1'b0;
    rd_n       = 1'b0;
    cyc();
    rd_n       = 1'b1;
    cyc();
    checks++;
    if (err_underrun !== 1'b1 || rx_count !== 5'd0) begin
      errors++;
      $display("FAIL underrun_sticky got err=%b cnt=%0d exp 1 0", err_underrun, rx_count);
    end
  endtask

  task automatic test_reset_mid();
    host_write = 1'b1;
    for (int i = 0; i < 5; i++) begin
      host_din = 8'h60 + 8'(i);
      cyc();
    end
    host_write = 1'b0;
    for (int i = 0; i < 5; i++) fpga_write(8'h20 + 8'(i));
    checks++;
    if (rx_count !== 5'd5 || tx_count !== 5'd5) begin
      errors++;
      $display("FAIL mid_prefill got rxc=%0d txc=%0d exp 5 5", rx_count, tx_count);
    end
    rd_n = 1'b0;
    #1;
    checks++;
    if (usb_data !== 8'h60) begin
      errors++;
      $display("FAIL mid_drive got %h exp 60", usb_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rx_count !== 5'd0 || tx_count !== 5'd0 ||
        rxf_n !== 1'b1 || txe_n !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset got rxc=%0d txc=%0d rxf_n=%b txe_n=%b exp 0 0 1 1",
               rx_count, tx_count, rxf_n, txe_n);
    end
    checks++;
    if (err_underrun !== 1'b0 || err_overrun !== 1'b0 || host_avail !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_flags got ur=%b ov=%b avail=%b exp 0 0 0",
               err_underrun, err_overrun, host_avail);
    end
    fpga_oe = 1'b1;
    fpga_d  = 8'h3C;
    #1;
    checks++;
    if (usb_data !== 8'h3C) begin
      errors++;
      $display("FAIL mid_bus_release got %h exp 3c", usb_data);
    end
    fpga_oe = 1'b0;
    rd_n    = 1'b1;
    cyc();
    #2;
    rst_n = 1'b1;
    #1;
    checks++;
    if (txe_n !== 1'b1) begin
      errors++;
      $display("FAIL mid_release_pre got txe_n=%b exp 1", txe_n);
    end
    cyc();
    checks++;
    if (txe_n !== 1'b0 || rxf_n !== 1'b1) begin
      errors++;
      $display("FAIL mid_release_post got txe_n=%b rxf_n=%b exp 0 1", txe_n, rxf_n);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    rd_n       = 1'b1;
    wr_n       = 1'b1;
    host_din   = 8'h00;
    host_write = 1'b0;
    host_read  = 1'b0;
    fpga_oe    = 1'b0;
    fpga_d     = 8'h00;
    test_reset();
    test_rx_basic();
    test_tx_basic();
    test_tx_full();
    test_rx_full_simul();
    test_underrun();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
